// File: rtl/srt_norm_ctrl_if.sv
// -----------------------------------------------------------------------------
// srt_norm_ctrl_if
// Purpose : Bundles the host request/result signals and the divider-side
//           signals of srt_norm_ctrl into one interface.
// Modports:
//   slave  - the controller: takes start/n_in/d_in and divider results,
//            drives ready, normalized operands, divider control and results.
//   master - the environment (host plus divider): the mirror image.
// Signals :
//   start, n_in[7:0], d_in[7:0]   host request
//   ready                         controller idle, start accepted
//   div_n[7:0], div_d[7:0]        normalized operands to the divider
//   div_enable, div_resetn        divider start level / active-low restart
//   div_done, div_q[7:0], div_r   divider completion and results
//   q_out, r_out, shamt, valid, err  captured result, shift, strobe, status
// -----------------------------------------------------------------------------
interface srt_norm_ctrl_if;
   logic       start;
   logic [7:0] n_in;
   logic [7:0] d_in;
   logic       ready;
   logic [7:0] div_n;
   logic [7:0] div_d;
   logic       div_enable;
   logic       div_resetn;
   logic       div_done;
   logic [7:0] div_q;
   logic [7:0] div_r;
   logic [7:0] q_out;
   logic [7:0] r_out;
   logic [2:0] shamt;
   logic       valid;
   logic [2:0] err;

   modport slave (
      input  start, n_in, d_in, div_done, div_q, div_r,
      output ready, div_n, div_d, div_enable, div_resetn,
             q_out, r_out, shamt, valid, err
   );

   modport master (
      output start, n_in, d_in, div_done, div_q, div_r,
      input  ready, div_n, div_d, div_enable, div_resetn,
             q_out, r_out, shamt, valid, err
   );
endinterface

// File: rtl/srt_norm_ctrl.sv
// -----------------------------------------------------------------------------
// srt_norm_ctrl
// Purpose : Front-end controller for an SRT divider. Latches a raw dividend
//           and divisor, left-normalizes them until divisor bit 6 is set,
//           rejects illegal operands, runs the divider and captures its
//           quotient/remainder. Results are passed through unscaled; the
//           true remainder is r_out >> shamt, applied downstream.
// Ports   :
//   clk    - rising-edge clock for all state
//   reset  - asynchronous active-high reset, clears all state
//   bus    - srt_norm_ctrl_if.slave (host request/result + divider signals)
// Status  : err = 000 ok, 001 divide-by-zero, 010 d_in[7]=1,
//           011 dividend overflow, 100 timeout.
// Option  : define SRT_NORM_TIMEOUT_EN to add a 4-bit WAIT watchdog that
//           fails the operation with err=100 if div_done does not arrive
//           within 15 cycles of WAIT entry. Without it WAIT lasts forever.
// -----------------------------------------------------------------------------
module srt_norm_ctrl (
   input  logic           clk,
   input  logic           reset,
   srt_norm_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_NORM, ST_ISSUE, ST_WAIT, ST_CAPT, ST_CLEAR, ST_FAIL
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] div_n_q, div_n_d;
   logic [7:0] div_d_q, div_d_d;
   logic [7:0] n_raw_q, n_raw_d;   // unshifted dividend, returned on failure
   logic [7:0] q_out_q, q_out_d;
   logic [7:0] r_out_q, r_out_d;
   logic [2:0] shamt_q, shamt_d;
   logic [2:0] err_q,   err_d;
`ifdef SRT_NORM_TIMEOUT_EN
   logic [3:0] tmo_q, tmo_d;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         div_n_q <= 8'h00;
         div_d_q <= 8'h00;
         n_raw_q <= 8'h00;
         q_out_q <= 8'h00;
         r_out_q <= 8'h00;
         shamt_q <= 3'd0;
         err_q   <= 3'b000;
`ifdef SRT_NORM_TIMEOUT_EN
         tmo_q   <= 4'd0;
`endif
      end else begin
         state_q <= state_d;
         div_n_q <= div_n_d;
         div_d_q <= div_d_d;
         n_raw_q <= n_raw_d;
         q_out_q <= q_out_d;
         r_out_q <= r_out_d;
         shamt_q <= shamt_d;
         err_q   <= err_d;
`ifdef SRT_NORM_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   // Results are loaded on the edge that enters CAPT/FAIL so they are
   // already stable during the single valid cycle.
   always_comb begin
      state_d = state_q;
      div_n_d = div_n_q;
      div_d_d = div_d_q;
      n_raw_d = n_raw_q;
      q_out_d = q_out_q;
      r_out_d = r_out_q;
      shamt_d = shamt_q;
      err_d   = err_q;
`ifdef SRT_NORM_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               div_n_d = bus.n_in;
               div_d_d = bus.d_in;
               n_raw_d = bus.n_in;
               shamt_d = 3'd0;
               err_d   = 3'b000;
               state_d = ST_NORM;
            end
         end
         ST_NORM: begin
            // Priority order matters: divisor checks precede the dividend
            // overflow check, so a normalized divisor wins over n[7]=1.
            if (div_d_q == 8'h00) begin
               err_d   = 3'b001;
               q_out_d = 8'hFF;
               r_out_d = n_raw_q;
               state_d = ST_FAIL;
            end else if (div_d_q[7]) begin
               err_d   = 3'b010;
               q_out_d = 8'hFF;
               r_out_d = n_raw_q;
               state_d = ST_FAIL;
            end else if (div_d_q[6]) begin
               state_d = ST_ISSUE;
            end else if (div_n_q[7]) begin
               err_d   = 3'b011;
               q_out_d = 8'hFF;
               r_out_d = n_raw_q;
               state_d = ST_FAIL;
            end else begin
               div_n_d = {div_n_q[6:0], 1'b0};
               div_d_d = {div_d_q[6:0], 1'b0};
               shamt_d = shamt_q + 3'd1;
            end
         end
         ST_ISSUE: begin
`ifdef SRT_NORM_TIMEOUT_EN
            tmo_d = 4'd0;
`endif
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.div_done) begin
               q_out_d = bus.div_q;
               r_out_d = bus.div_r;
               state_d = ST_CAPT;
            end
`ifdef SRT_NORM_TIMEOUT_EN
            else begin
               // Count reaches 15 on the 15th WAIT edge; that edge enters
               // FAIL, so the strobe lands 15 cycles after WAIT entry.
               tmo_d = tmo_q + 4'd1;
               if (tmo_d == 4'd15) begin
                  err_d   = 3'b100;
                  q_out_d = 8'hFF;
                  r_out_d = n_raw_q;
                  state_d = ST_FAIL;
               end
            end
`endif
         end
         ST_CAPT:  state_d = ST_CLEAR;
         ST_FAIL:  state_d = ST_CLEAR;
         ST_CLEAR: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign bus.ready      = (state_q == ST_IDLE);
   assign bus.div_enable = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   // Divider restart is also held low while our own reset is asserted.
   assign bus.div_resetn = ~reset && (state_q != ST_CLEAR);
   assign bus.valid      = (state_q == ST_CAPT) || (state_q == ST_FAIL);
   assign bus.div_n      = div_n_q;
   assign bus.div_d      = div_d_q;
   assign bus.q_out      = q_out_q;
   assign bus.r_out      = r_out_q;
   assign bus.shamt      = shamt_q;
   assign bus.err        = err_q;

endmodule
